unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one external single-port memory between the core's instruction-fetch bus and its data bus. It sits between `top` and the memory model. Data accesses win by default. A starvation guard forces an instruction grant after STARVE_LIMIT consecutive data grants while a fetch is waiting. Per-port acknowledge handshakes are active-low, matching the core's ACKI_n/ACKD_n convention.

Parameters:
BIT_WIDTH, 32, address/data width
STARVE_LIMIT, 4, max consecutive data grants while IREQ is pending
CNT_W, 3, width of the starvation counter (must hold STARVE_LIMIT)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
IREQ  in  1  core fetch request, held until ACKI_n pulse
IAD  in  BIT_WIDTH  fetch address
ACKI_n  out  1  fetch ack, one-cycle low pulse
IDT  out  BIT_WIDTH  fetched instruction, valid while ACKI_n=0
MREQ  in  1  core data request, held until ACKD_n pulse
WRITE  in  1  1=store, 0=load
SIZE  in  2  00 word, 01 half, 1x byte
DAD  in  BIT_WIDTH  data address
DDT_O  in  BIT_WIDTH  store data from core
DDT_I  out  BIT_WIDTH  load data to core, valid while ACKD_n=0
ACKD_n  out  1  data ack, one-cycle low pulse
M_REQ  out  1  memory request
M_WRITE  out  1  memory write enable
M_SIZE  out  2  memory access size
M_ADDR  out  BIT_WIDTH  memory address
M_WDATA  out  BIT_WIDTH  memory write data
M_ACK_n  in  1  memory ack, active low, any latency ≥0 cycles after M_REQ
M_RDATA  in  BIT_WIDTH  memory read data, valid with M_ACK_n=0
M_OWNER  out  1  0=instruction owns memory, 1=data owns memory (valid while M_REQ=1)

Behaviour:
- Reset values (async, rst=1):
  - state IDLE; M_REQ=0, M_WRITE=0, M_SIZE=00, M_ADDR=0, M_WDATA=0, M_OWNER=0.
  - ACKI_n=1, ACKD_n=1, IDT=0, DDT_I=0, starvation counter=0.
  - A reset mid-transaction aborts it; no ack is issued for the aborted request.
- State machine: IDLE, I_BUSY, D_BUSY.
- IDLE, per clock edge:
  - if MREQ=1 and not (IREQ=1 and cnt==STARVE_LIMIT): go to D_BUSY.
  - else if IREQ=1: go to I_BUSY.
  - else: stay in IDLE.
- Grant capture: on the granting edge, latch the request into the M_* registers.
  - Instruction grant: M_ADDR=IAD, M_SIZE=00, M_WRITE=0, M_OWNER=0.
  - Data grant: M_ADDR=DAD, M_SIZE=SIZE, M_WRITE=WRITE, M_WDATA=DDT_O, M_OWNER=1.
- In both busy states, M_REQ=1 and the M_* outputs stay stable until the memory acknowledges.
- Busy state with M_ACK_n=0 sampled at an edge:
  - Registered response: the owning port's ack goes low for exactly one cycle.
  - IDT or DDT_I captures M_RDATA; a store captures M_RDATA too, and its value is don't-care.
  - M_REQ drops and the state returns to IDLE.
- Busy state with M_ACK_n=1: hold. There is no timeout.
- Latency with a zero-wait memory that acks combinationally in the first M_REQ cycle:
  - request seen at edge k, memory ack sampled at edge k+1, port ack low during cycle k+1..k+2;
  - next grant possible at edge k+2, so each transaction costs 2 cycles minimum.
- Back-to-back: at least one IDLE cycle separates transactions. ACKI_n and ACKD_n are never low in the same cycle.
- Request dropped by the core mid-transaction: the transaction still completes and the ack pulse is still issued.
- A requester that keeps its request high after its ack is treated as a new request.
- Starvation counter:
  - on a data grant with IREQ=1: increment, saturating at STARVE_LIMIT;
  - on an instruction grant: clear;
  - in any cycle in IDLE with IREQ=0: clear.
- Width/data rules:
  - read data passes through unmodified; the memory right-justifies and zero-extends sub-word loads;
  - store data passes through unmodified; the memory selects byte lanes by M_SIZE.
- Unsupported input: SIZE=10/11 are both byte; the arbiter does not decode them further.

Decomposition:
- Shared package `mem_bus_pkg`:
  - state encoding (IDLE/I_BUSY/D_BUSY);
  - SIZE codes (SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10);
  - MMIO constants STDOUT_ADDR=32'hf0000000 and EXIT_ADDR=32'hff000000.
- No sub-module. The FSM, grant-capture registers and starvation counter live in one module.

Test Plan:
1. Fetch only: IREQ=1, IAD=0x00000010, memory acks first cycle with M_RDATA=0x24020005 → M_ADDR=0x10, M_SIZE=00, M_OWNER=0; ACKI_n low for one cycle 2 cycles after request, IDT=0x24020005.
2. Simultaneous: IREQ=1 and MREQ=1 (load, DAD=0x80000004, SIZE=00), memory returns 0xDEADBEEF → data served first (ACKD_n pulse, DDT_I=0xDEADBEEF); instruction served next, ACKI_n pulse 2 cycles later.
3. Starvation, STARVE_LIMIT=4: MREQ held high continuously, IREQ held high → exactly 4 ACKD_n pulses, then 1 ACKI_n pulse, then data resumes; counter returns to 0.
4. Byte store to STDOUT: MREQ=1, WRITE=1, SIZE=10, DAD=0xf0000000, DDT_O=0x00000041, memory waits 3 cycles → M_* stable all 3 wait cycles, M_WDATA=0x41, M_SIZE=10; a single ACKD_n pulse follows the memory ack.
5. Reset mid-transaction: data grant, memory stalled, rst=1 asynchronously → M_REQ=0 and ACKD_n=1 immediately; no ack after rst drops; a fresh IREQ is granted normally.
6. Request withdrawn: MREQ high for 1 cycle only, memory acks 2 cycles later → ACKD_n still pulses once, and no second transaction starts.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared memory-bus state encoding, access-size codes and MMIO addresses
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [31:0] STDOUT_ADDR = 32'hf0000000;
  localparam logic [31:0] EXIT_ADDR = 32'hff000000;
endpackage

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between fetch and data buses, data-first with starvation guard
module unified_mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IREQ,
  input  logic [BIT_WIDTH-1:0] IAD,
  output logic                 ACKI_n,
  output logic [BIT_WIDTH-1:0] IDT,
  input  logic                 MREQ,
  input  logic                 WRITE,
  input  logic [1:0]           SIZE,
  input  logic [BIT_WIDTH-1:0] DAD,
  input  logic [BIT_WIDTH-1:0] DDT_O,
  output logic [BIT_WIDTH-1:0] DDT_I,
  output logic                 ACKD_n,
  output logic                 M_REQ,
  output logic                 M_WRITE,
  output logic [1:0]           M_SIZE,
  output logic [BIT_WIDTH-1:0] M_ADDR,
  output logic [BIT_WIDTH-1:0] M_WDATA,
  input  logic                 M_ACK_n,
  input  logic [BIT_WIDTH-1:0] M_RDATA,
  output logic                 M_OWNER
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic starved;
  assign starved = IREQ && cnt == CNT_W'(STARVE_LIMIT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      M_REQ <= 1'b0;
      M_WRITE <= 1'b0;
      M_SIZE <= SZ_WORD;
      M_ADDR <= '0;
      M_WDATA <= '0;
      M_OWNER <= 1'b0;
      ACKI_n <= 1'b1;
      ACKD_n <= 1'b1;
      IDT <= '0;
      DDT_I <= '0;
    end else begin
      ACKI_n <= 1'b1;
      ACKD_n <= 1'b1;
      case (state)
        IDLE:
          if (MREQ && !starved) begin
            state <= D_BUSY;
            M_REQ <= 1'b1;
            M_WRITE <= WRITE;
            M_SIZE <= SIZE;
            M_ADDR <= DAD;
            M_WDATA <= DDT_O;
            M_OWNER <= 1'b1;
            // a data grant with IREQ pending implies cnt < limit, so this saturates
            cnt <= IREQ ? cnt + 1'b1 : '0;
          end else if (IREQ) begin
            state <= I_BUSY;
            M_REQ <= 1'b1;
            M_WRITE <= 1'b0;
            M_SIZE <= SZ_WORD;
            M_ADDR <= IAD;
            M_OWNER <= 1'b0;
            cnt <= '0;
          end else
            cnt <= '0;
        default:
          if (!M_ACK_n) begin
            state <= IDLE;
            M_REQ <= 1'b0;
            if (state == I_BUSY) begin
              ACKI_n <= 1'b0;
              IDT <= M_RDATA;
            end else begin
              ACKD_n <= 1'b0;
              DDT_I <= M_RDATA;
            end
          end
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: random and directed checks of the arbiter against a transaction-level model
module tb_unified_mem_arbiter;
  localparam int LIM = 4;
  logic clk = 0, rst = 1;
  logic IREQ = 0, MREQ = 0, WRITE = 0, M_ACK_n = 1;
  logic [1:0] SIZE = 0;
  logic [31:0] IAD = 0, DAD = 0, DDT_O = 0, M_RDATA = 0;
  logic ACKI_n, ACKD_n, M_REQ, M_WRITE, M_OWNER;
  logic [1:0] M_SIZE;
  logic [31:0] IDT, DDT_I, M_ADDR, M_WDATA;

  unified_mem_arbiter dut (
    .clk(clk), .rst(rst), .IREQ(IREQ), .IAD(IAD), .ACKI_n(ACKI_n), .IDT(IDT),
    .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .DAD(DAD), .DDT_O(DDT_O),
    .DDT_I(DDT_I), .ACKD_n(ACKD_n), .M_REQ(M_REQ), .M_WRITE(M_WRITE),
    .M_SIZE(M_SIZE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_ACK_n(M_ACK_n),
    .M_RDATA(M_RDATA), .M_OWNER(M_OWNER)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int owner, streak;
  logic e_req, e_wr, e_own, e_acki, e_ackd;
  logic [1:0] e_sz;
  logic [31:0] e_addr, e_wd, e_idt, e_ddt;
  bit mact, mem_rand, rd_fixed;
  int mleft, mem_wait;
  logic [31:0] rd_val;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask

  // owner: 0 = memory free, 1 = fetch transaction open, 2 = data transaction open
  task automatic model_reset();
    owner = 0; streak = 0;
    e_req = 0; e_wr = 0; e_own = 0; e_acki = 1; e_ackd = 1;
    e_sz = 0; e_addr = 0; e_wd = 0; e_idt = 0; e_ddt = 0;
  endtask

  task automatic model_edge();
    e_acki = 1; e_ackd = 1;
    if (owner == 0) begin
      if (MREQ && !(IREQ && streak == LIM)) begin
        owner = 2; e_req = 1; e_wr = WRITE; e_sz = SIZE; e_addr = DAD; e_wd = DDT_O; e_own = 1;
        streak = IREQ ? ((streak < LIM) ? streak + 1 : LIM) : 0;
      end else if (IREQ) begin
        owner = 1; e_req = 1; e_wr = 0; e_sz = 0; e_addr = IAD; e_own = 0; streak = 0;
      end else streak = 0;
    end else if (!M_ACK_n) begin
      if (owner == 1) begin e_acki = 0; e_idt = M_RDATA; end
      else begin e_ackd = 0; e_ddt = M_RDATA; end
      owner = 0; e_req = 0;
    end
  endtask

  task automatic drive_mem();
    if (!M_REQ) begin
      mact = 0; M_ACK_n = 1;
    end else begin
      if (!mact) begin
        mact = 1;
        mleft = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
      end
      if (mleft == 0) begin
        M_ACK_n = 0;
        M_RDATA = rd_fixed ? rd_val : $urandom;
      end else begin
        mleft--; M_ACK_n = 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
    chk("M_REQ", M_REQ, e_req);
    chk("M_WRITE", M_WRITE, e_wr);
    chk("M_SIZE", M_SIZE, e_sz);
    chk("M_ADDR", M_ADDR, e_addr);
    chk("M_WDATA", M_WDATA, e_wd);
    chk("M_OWNER", M_OWNER, e_own);
    chk("ACKI_n", ACKI_n, e_acki);
    chk("ACKD_n", ACKD_n, e_ackd);
    chk("IDT", IDT, e_idt);
    chk("DDT_I", DDT_I, e_ddt);
    chk("ack_exclusive", ACKI_n | ACKD_n, 1);
    drive_mem();
  endtask

  initial begin
    int n, k;
    string seq;
    model_reset();
    mact = 0; mem_rand = 0; rd_fixed = 1; mem_wait = 0; rd_val = 0;
    repeat (2) cyc();
    chk("rst_mreq", M_REQ, 0);
    chk("rst_acki", ACKI_n, 1);
    chk("rst_ackd", ACKD_n, 1);
    chk("rst_maddr", M_ADDR, 0);
    rst = 0;
    cyc();

    // fetch only
    rd_val = 32'h24020005;
    IREQ = 1; IAD = 32'h10;
    cyc();
    chk("t1_addr", M_ADDR, 32'h10);
    chk("t1_size", M_SIZE, 0);
    chk("t1_owner", M_OWNER, 0);
    cyc();
    chk("t1_acki", ACKI_n, 0);
    chk("t1_idt", IDT, 32'h24020005);
    IREQ = 0;
    cyc();
    chk("t1_acki_end", ACKI_n, 1);

    // simultaneous: data first, fetch next
    rd_val = 32'hDEADBEEF;
    IREQ = 1; IAD = 32'h20; MREQ = 1; WRITE = 0; SIZE = 2'b00; DAD = 32'h80000004;
    cyc();
    chk("t2_owner_d", M_OWNER, 1);
    chk("t2_addr_d", M_ADDR, 32'h80000004);
    cyc();
    chk("t2_ackd", ACKD_n, 0);
    chk("t2_ddt", DDT_I, 32'hDEADBEEF);
    chk("t2_acki_hi", ACKI_n, 1);
    MREQ = 0;
    cyc();
    chk("t2_owner_i", M_OWNER, 0);
    chk("t2_addr_i", M_ADDR, 32'h20);
    cyc();
    chk("t2_acki", ACKI_n, 0);
    chk("t2_idt", IDT, 32'hDEADBEEF);
    IREQ = 0;
    cyc();

    // starvation guard: both held high
    IREQ = 1; MREQ = 1; seq = "";
    repeat (20) begin
      cyc();
      if (!ACKD_n) seq = {seq, "D"};
      if (!ACKI_n) seq = {seq, "I"};
    end
    checks++;
    if (seq != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL starve_order got=%s exp=DDDDIDDDDI", seq);
    end
    IREQ = 0; MREQ = 0;
    repeat (3) cyc();

    // byte store to STDOUT with 3 wait cycles
    mem_wait = 3;
    MREQ = 1; WRITE = 1; SIZE = 2'b10; DAD = 32'hf0000000; DDT_O = 32'h41;
    cyc();
    n = 0; k = 0;
    while (ACKD_n && k < 10) begin
      cyc(); k++;
      if (ACKD_n) begin
        n++;
        chk("t4_wdata", M_WDATA, 32'h41);
        chk("t4_size", M_SIZE, 2'b10);
        chk("t4_req", M_REQ, 1);
      end
    end
    chk("t4_waits", n, 3);
    chk("t4_ackd", ACKD_n, 0);
    MREQ = 0; WRITE = 0;
    cyc();
    chk("t4_single_ack", ACKD_n, 1);

    // async reset mid-transaction
    mem_wait = 5;
    MREQ = 1; SIZE = 0; DAD = 32'h100;
    cyc();
    cyc();
    #2 rst = 1;
    #1 chk("t5_mreq", M_REQ, 0);
    chk("t5_ackd", ACKD_n, 1);
    MREQ = 0;
    cyc();
    rst = 0;
    n = 0;
    repeat (4) begin cyc(); if (!ACKD_n) n++; end
    chk("t5_no_ack", n, 0);
    mem_wait = 0;
    IREQ = 1; IAD = 32'h44;
    cyc();
    chk("t5_regrant", M_ADDR, 32'h44);
    cyc();
    chk("t5_acki", ACKI_n, 0);
    IREQ = 0;
    cyc();

    // request withdrawn after one cycle
    mem_wait = 2;
    MREQ = 1; DAD = 32'h200;
    cyc();
    MREQ = 0;
    n = 0; k = 0;
    repeat (8) begin
      cyc();
      if (!ACKD_n) n++;
      else if (n > 0 && M_REQ) k++;
    end
    chk("t6_ack_once", n, 1);
    chk("t6_no_retx", k, 0);

    // randomized traffic
    mem_rand = 1; rd_fixed = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (rst) rst = 0;
      else if ($urandom_range(0, 499) == 0) rst = 1;
      if (!ACKI_n) IREQ = ($urandom_range(0, 3) == 0);
      else if (!IREQ) begin
        IREQ = $urandom_range(0, 1);
        IAD = $urandom;
      end else if ($urandom_range(0, 15) == 0) IREQ = 0;
      if (!ACKD_n) MREQ = ($urandom_range(0, 3) == 0);
      else if (!MREQ) begin
        MREQ = $urandom_range(0, 1);
        WRITE = $urandom_range(0, 1);
        SIZE = $urandom_range(0, 3);
        DAD = $urandom;
        DDT_O = $urandom;
      end else if ($urandom_range(0, 15) == 0) MREQ = 0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
